// File: rtl/pagerank_scatter_csr_if.sv
// Purpose : output beat bus from the PageRank scatter stage to the gather stage.
// Latency : n/a (wires only).
// Backpressure: valid/ready; the master holds every field stable while out_valid=1 and out_ready=0.
// Signals:
//   out_valid       beat present
//   out_ready       gather stage accepts the beat
//   out_lane_valid  per-lane valid mask, lane 0 filled first
//   out_node_id     destination id per lane (0 on unused lanes)
//   out_contrib     contribution shared by all lanes of the beat
//   out_last        final beat for the current source node
interface pagerank_scatter_csr_if #(
    parameter int LANES  = 2,
    parameter int ID_W   = 32,
    parameter int RANK_W = 64
);
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES-1:0]            out_lane_valid;
    logic [LANES-1:0][ID_W-1:0]  out_node_id;
    logic [RANK_W-1:0]           out_contrib;
    logic                        out_last;

    modport master (
        output out_valid,
        output out_lane_valid,
        output out_node_id,
        output out_contrib,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_lane_valid,
        input  out_node_id,
        input  out_contrib,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/pagerank_scatter_csr.sv
// Purpose : walk one CSR partition, divide each source rank by its out-degree and stream
//           the contribution to up to LANES destinations per beat; sum dangling ranks.
// Latency : per source 1 + RANK_W + ceil(deg/LANES) + 1 cycles (2 if dangling), +2 per pass.
// Backpressure: out_valid is held with all fields stable until out_ready; the walk stalls meanwhile.
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   start                 begin a pass (sampled only while idle)
//   source_id, row_ptr,   partition description in CSR form
//   col_idx
//   page_rank_old         previous-iteration ranks of the whole graph
//   out_if (master)       beat stream to the gather stage
//   busy, done            pass in progress / one-cycle end-of-pass pulse
//   dangling_sum          saturating sum of zero out-degree source ranks this pass
//   csr_error             sticky flag for malformed pointers or out-of-range source ids
module pagerank_scatter_csr #(
    parameter int NODES_IN_PARTITION = 4,
    parameter int EDGES_IN_PARTITION = 32,
    parameter int NODES_IN_GRAPH     = 32,
    parameter int RANK_W             = 64,
    parameter int ID_W               = 32,
    parameter int LANES              = 2
) (
    input  logic                                         clock,
    input  logic                                         reset_n,
    input  logic                                         start,
    input  logic [NODES_IN_PARTITION-1:0][ID_W-1:0]      source_id,
    input  logic [NODES_IN_PARTITION:0][ID_W-1:0]        row_ptr,
    input  logic [EDGES_IN_PARTITION-1:0][ID_W-1:0]      col_idx,
    input  logic [NODES_IN_GRAPH-1:0][RANK_W-1:0]        page_rank_old,
    pagerank_scatter_csr_if.master                       out_if,
    output logic                                         busy,
    output logic                                         done,
    output logic [RANK_W-1:0]                            dangling_sum,
    output logic                                         csr_error
);
    localparam int IW = $clog2(NODES_IN_PARTITION + 1);
    localparam int KW = $clog2(LANES + 1);
    localparam int CW = $clog2(RANK_W);
    // Remainder must hold twice the largest divisor, which is an ID_W-wide degree.
    localparam int DW = ((RANK_W > ID_W) ? RANK_W : ID_W) + 1;

    localparam logic [IW-1:0]   LAST_I    = IW'(NODES_IN_PARTITION);
    localparam logic [CW-1:0]   LAST_DIV  = CW'(RANK_W - 1);
    localparam logic [ID_W-1:0] EDGES_LIM = ID_W'(EDGES_IN_PARTITION);
    localparam logic [ID_W-1:0] LANES_W   = ID_W'(LANES);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DIVIDE, S_EMIT, S_NEXT, S_DONE} state_t;

    state_t             state;
    logic [IW-1:0]      i;
    logic [ID_W-1:0]    e;
    logic [KW-1:0]      k_cur;
    logic [RANK_W-1:0]  contrib;
    logic [DW-1:0]      rem;
    logic [RANK_W-1:0]  quo;
    logic [ID_W-1:0]    div_b;
    logic [CW-1:0]      div_cnt;

    // Current source node lookups.
    logic [ID_W-1:0]    rp_lo, rp_hi, sid, deg;
    logic [RANK_W-1:0]  rank_sel, rank_in;
    logic               sid_ok, ptr_bad, dangle;
    logic [RANK_W:0]    sum_ext;
    logic [RANK_W-1:0]  sat_sum;

    always_comb begin
        rp_lo = '0;
        rp_hi = '0;
        sid   = '0;
        for (int n = 0; n < NODES_IN_PARTITION; n++) begin
            if (i == IW'(n)) begin
                rp_lo = row_ptr[n];
                rp_hi = row_ptr[n+1];
                sid   = source_id[n];
            end
        end
    end

    always_comb begin
        rank_sel = '0;
        for (int n = 0; n < NODES_IN_GRAPH; n++) begin
            if (sid == ID_W'(n)) rank_sel = page_rank_old[n];
        end
    end

    always_comb begin
        sid_ok  = (sid < ID_W'(NODES_IN_GRAPH));
        ptr_bad = (rp_hi < rp_lo) || (rp_hi > EDGES_LIM);
        deg     = rp_hi - rp_lo;
        dangle  = ptr_bad || !sid_ok || (deg == '0);
        // An out-of-range source behaves as a dangling node of rank 0.
        rank_in = sid_ok ? rank_sel : '0;
        sum_ext = {1'b0, dangling_sum} + {1'b0, rank_in};
        sat_sum = sum_ext[RANK_W] ? '1 : sum_ext[RANK_W-1:0];
    end

    // Restoring divider step: dividend bits shift out of quo's MSB into rem,
    // quotient bits shift into quo's LSB.
    logic [DW-1:0]      rem_shift, b_ext, rem_next;
    logic               q_bit;
    logic [RANK_W-1:0]  quo_next;

    always_comb begin
        rem_shift = {rem[DW-2:0], quo[RANK_W-1]};
        b_ext     = DW'(div_b);
        q_bit     = (rem_shift >= b_ext);
        rem_next  = q_bit ? (rem_shift - b_ext) : rem_shift;
        quo_next  = {quo[RANK_W-2:0], q_bit};
    end

    // Next beat contents. Leaving DIVIDE the beat starts at row_ptr[i]; inside EMIT
    // it starts just past the beat currently on the bus.
    logic [ID_W-1:0]            base, remaining, idx;
    logic [KW-1:0]              k_nxt;
    logic                       last_nxt;
    logic [LANES-1:0]           lane_vld;
    logic [LANES-1:0][ID_W-1:0] lane_id;

    always_comb begin
        base      = (state == S_EMIT) ? (e + ID_W'(k_cur)) : rp_lo;
        remaining = rp_hi - base;
        k_nxt     = (remaining > LANES_W) ? KW'(LANES) : KW'(remaining);
        last_nxt  = (remaining <= LANES_W);
        lane_vld  = '0;
        lane_id   = '0;
        idx       = '0;
        for (int n = 0; n < LANES; n++) begin
            if (ID_W'(n) < remaining) begin
                lane_vld[n] = 1'b1;
                idx         = base + ID_W'(n);
                for (int m = 0; m < EDGES_IN_PARTITION; m++) begin
                    if (idx == ID_W'(m)) lane_id[n] = col_idx[m];
                end
            end
        end
    end

    assign out_if.out_contrib = contrib;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= S_IDLE;
            i                     <= '0;
            e                     <= '0;
            k_cur                 <= '0;
            contrib               <= '0;
            rem                   <= '0;
            quo                   <= '0;
            div_b                 <= '0;
            div_cnt               <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            dangling_sum          <= '0;
            csr_error             <= 1'b0;
            out_if.out_valid      <= 1'b0;
            out_if.out_lane_valid <= '0;
            out_if.out_node_id    <= '0;
            out_if.out_last       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i            <= '0;
                        csr_error    <= 1'b0;
                        dangling_sum <= '0;
                        busy         <= 1'b1;
                        state        <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (i == LAST_I) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        if (ptr_bad || !sid_ok) csr_error <= 1'b1;
                        if (dangle) begin
                            dangling_sum <= sat_sum;
                            state        <= S_NEXT;
                        end else begin
                            rem     <= '0;
                            quo     <= rank_in;
                            div_b   <= deg;
                            div_cnt <= '0;
                            state   <= S_DIVIDE;
                        end
                    end
                end
                S_DIVIDE: begin
                    rem     <= rem_next;
                    quo     <= quo_next;
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == LAST_DIV) begin
                        contrib               <= quo_next;
                        e                     <= base;
                        k_cur                 <= k_nxt;
                        out_if.out_valid      <= 1'b1;
                        out_if.out_lane_valid <= lane_vld;
                        out_if.out_node_id    <= lane_id;
                        out_if.out_last       <= last_nxt;
                        state                 <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_if.out_ready) begin
                        if (out_if.out_last) begin
                            out_if.out_valid      <= 1'b0;
                            out_if.out_lane_valid <= '0;
                            out_if.out_node_id    <= '0;
                            out_if.out_last       <= 1'b0;
                            state                 <= S_NEXT;
                        end else begin
                            e                     <= base;
                            k_cur                 <= k_nxt;
                            out_if.out_lane_valid <= lane_vld;
                            out_if.out_node_id    <= lane_id;
                            out_if.out_last       <= last_nxt;
                        end
                    end
                end
                S_NEXT: begin
                    i     <= i + 1'b1;
                    state <= S_FETCH;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pagerank_scatter_csr.sv
module tb_pagerank_scatter_csr;
    localparam int RW  = 16;
    localparam int IDW = 32;
    localparam int NP  = 4;
    localparam int NE  = 32;
    localparam int NG  = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                      reset_n;
    logic                      start0, start1;
    logic [NP-1:0][IDW-1:0]    source_id;
    logic [NP:0][IDW-1:0]      row_ptr;
    logic [NE-1:0][IDW-1:0]    col_idx;
    logic [NG-1:0][RW-1:0]     page_rank_old;
    logic                      busy0, done0, err0, busy1, done1, err1;
    logic [RW-1:0]             dsum0, dsum1;

    pagerank_scatter_csr_if #(.LANES(2), .ID_W(IDW), .RANK_W(RW)) if0 ();
    pagerank_scatter_csr_if #(.LANES(1), .ID_W(IDW), .RANK_W(RW)) if1 ();

    pagerank_scatter_csr #(
        .NODES_IN_PARTITION(NP), .EDGES_IN_PARTITION(NE), .NODES_IN_GRAPH(NG),
        .RANK_W(RW), .ID_W(IDW), .LANES(2)
    ) u_dut (
        .clock(clock), .reset_n(reset_n), .start(start0),
        .source_id(source_id), .row_ptr(row_ptr), .col_idx(col_idx),
        .page_rank_old(page_rank_old), .out_if(if0),
        .busy(busy0), .done(done0), .dangling_sum(dsum0), .csr_error(err0)
    );

    pagerank_scatter_csr #(
        .NODES_IN_PARTITION(NP), .EDGES_IN_PARTITION(NE), .NODES_IN_GRAPH(NG),
        .RANK_W(RW), .ID_W(IDW), .LANES(1)
    ) u_dut1 (
        .clock(clock), .reset_n(reset_n), .start(start1),
        .source_id(source_id), .row_ptr(row_ptr), .col_idx(col_idx),
        .page_rank_old(page_rank_old), .out_if(if1),
        .busy(busy1), .done(done1), .dangling_sum(dsum1), .csr_error(err1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Beat image: {last, contrib, mask[1:0], id1, id0}
    typedef logic [82:0] beat_t;
    beat_t exp_q[$];
    int    beats_seen;

    typedef struct {
        int unsigned rp[5];
        int unsigned sid[4];
        int unsigned rank[4];
        int unsigned cols[8];
        bit          stall;
        bit          lanes1;
        int unsigned exp_dsum;
        bit          exp_err;
        int          exp_cycles;
        int          exp_beats;
    } vec_t;

    localparam int NV = 8;
    vec_t tbl[NV];

    // Ready drivers: lanes-2 DUT follows 1,0,0,1 while a beat is on the bus in stall mode.
    bit         stall_mode = 0;
    int         ph = 0;
    logic [3:0] pat = 4'b1001;

    initial begin
        if0.out_ready = 1'b1;
        if1.out_ready = 1'b1;
    end

    always @(posedge clock) begin
        #1;
        if (stall_mode && if0.out_valid) begin
            if0.out_ready = pat[ph];
            ph = (ph + 1) % 4;
        end else begin
            if0.out_ready = 1'b1;
        end
    end

    // Scoreboard monitors, sampling on the falling edge.
    beat_t held0, held1, cur0, cur1, exp_b;
    bit    hold0 = 0, hold1 = 0;

    always @(negedge clock) begin
        cur0 = {if0.out_last, if0.out_contrib, if0.out_lane_valid, if0.out_node_id[1], if0.out_node_id[0]};
        if (!reset_n) begin
            hold0 = 0;
        end else begin
            if (hold0) check("hold_stable0", {if0.out_valid, cur0}, {1'b1, held0});
            if (if0.out_valid && if0.out_ready) begin
                beats_seen++;
                check("beat_expected0", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check("beat0", cur0, exp_b);
                end
            end
            if (done0) check("done_with_valid0", if0.out_valid, 1'b0);
            hold0 = if0.out_valid && !if0.out_ready;
            held0 = cur0;
        end
    end

    always @(negedge clock) begin
        cur1 = {if1.out_last, if1.out_contrib, 1'b0, if1.out_lane_valid, 32'd0, if1.out_node_id[0]};
        if (!reset_n) begin
            hold1 = 0;
        end else begin
            if (hold1) check("hold_stable1", {if1.out_valid, cur1}, {1'b1, held1});
            if (if1.out_valid && if1.out_ready) begin
                beats_seen++;
                check("beat_expected1", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check("beat1", cur1, exp_b);
                end
            end
            if (done1) check("done_with_valid1", if1.out_valid, 1'b0);
            hold1 = if1.out_valid && !if1.out_ready;
            held1 = cur1;
        end
    end

    task automatic load(input vec_t v);
        for (int n = 0; n <= NP; n++) row_ptr[n] = v.rp[n];
        for (int n = 0; n < NP; n++) source_id[n] = v.sid[n];
        for (int n = 0; n < NE; n++) col_idx[n] = (n < 8) ? v.cols[n] : 100 + n;
        for (int n = 0; n < NG; n++) page_rank_old[n] = 16'(n * 3 + 1);
        for (int n = 0; n < NP; n++) if (v.sid[n] < NG) page_rank_old[v.sid[n]] = 16'(v.rank[n]);
    endtask

    // Reference model: floor(rank/deg) per valid non-dangling source, split into LANES-wide beats.
    task automatic push_model(input int unsigned lanes);
        for (int j = 0; j < NP; j++) begin
            int unsigned lo, hi, s, c, k;
            lo = row_ptr[j];
            hi = row_ptr[j+1];
            s  = source_id[j];
            if (hi < lo || hi > NE || s >= NG || hi == lo) continue;
            c = page_rank_old[s] / (hi - lo);
            for (int unsigned ed = lo; ed < hi; ed += lanes) begin
                k = ((hi - ed) < lanes) ? (hi - ed) : lanes;
                exp_q.push_back({(ed + k == hi), 16'(c), (k == 2) ? 2'b11 : 2'b01,
                                 (k == 2) ? col_idx[ed+1] : 32'd0, col_idx[ed]});
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        load(v);
        push_model(v.lanes1 ? 1 : 2);
        stall_mode = v.stall;
        ph         = 0;
        beats_seen = 0;
        @(negedge clock);
        if (v.lanes1) start1 = 1'b1;
        else          start0 = 1'b1;
        @(posedge clock);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        cyc    = 1;
        check({tag, "_busy_after_start"}, v.lanes1 ? busy1 : busy0, 1'b1);
        check({tag, "_err_cleared"},      v.lanes1 ? err1 : err0, 1'b0);
        check({tag, "_dsum_cleared"},     v.lanes1 ? dsum1 : dsum0, 16'd0);
        while (((v.lanes1 ? done1 : done0) == 1'b0) && cyc < 3000) begin
            // A start pulse in mid-pass must be ignored.
            start1 = v.lanes1 && (cyc == 5);
            @(posedge clock);
            #1;
            cyc++;
        end
        start1 = 1'b0;
        check({tag, "_done_seen"},   v.lanes1 ? done1 : done0, 1'b1);
        check({tag, "_cycles"},      cyc, v.exp_cycles);
        check({tag, "_dangling"},    v.lanes1 ? dsum1 : dsum0, v.exp_dsum);
        check({tag, "_csr_error"},   v.lanes1 ? err1 : err0, v.exp_err);
        check({tag, "_beat_count"},  beats_seen, v.exp_beats);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        @(posedge clock);
        #1;
        check({tag, "_done_one_cycle"}, v.lanes1 ? done1 : done0, 1'b0);
        check({tag, "_idle_busy"},      v.lanes1 ? busy1 : busy0, 1'b0);
        stall_mode = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;

        tbl[0].rp = '{0, 3, 3, 3, 3};     tbl[0].sid = '{0, 1, 2, 3};
        tbl[0].rank = '{100, 10, 20, 30}; tbl[0].cols = '{5, 6, 7, 0, 0, 0, 0, 0};
        tbl[0].stall = 0; tbl[0].lanes1 = 0;
        tbl[0].exp_dsum = 60; tbl[0].exp_err = 0; tbl[0].exp_cycles = 28; tbl[0].exp_beats = 2;

        tbl[1] = tbl[0];
        tbl[1].stall = 1; tbl[1].exp_cycles = 30;

        tbl[2].rp = '{0, 0, 0, 0, 0};     tbl[2].sid = '{0, 1, 2, 3};
        tbl[2].rank = '{16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0};
        tbl[2].cols = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].stall = 0; tbl[2].lanes1 = 0;
        tbl[2].exp_dsum = 16'hFFFF; tbl[2].exp_err = 0; tbl[2].exp_cycles = 10; tbl[2].exp_beats = 0;

        tbl[3].rp = '{0, 2, 1, 1, 1};     tbl[3].sid = '{0, 1, 2, 3};
        tbl[3].rank = '{50, 11, 12, 13};  tbl[3].cols = '{40, 41, 42, 43, 0, 0, 0, 0};
        tbl[3].stall = 0; tbl[3].lanes1 = 0;
        tbl[3].exp_dsum = 36; tbl[3].exp_err = 1; tbl[3].exp_cycles = 27; tbl[3].exp_beats = 1;

        tbl[4].rp = '{0, 1, 4, 5, 5};     tbl[4].sid = '{8, 9, 10, 11};
        tbl[4].rank = '{9, 1000, 65535, 77}; tbl[4].cols = '{20, 21, 22, 23, 24, 0, 0, 0};
        tbl[4].stall = 0; tbl[4].lanes1 = 0;
        tbl[4].exp_dsum = 77; tbl[4].exp_err = 0; tbl[4].exp_cycles = 62; tbl[4].exp_beats = 4;

        tbl[5].rp = '{0, 0, 2, 2, 4};     tbl[5].sid = '{4, 40, 6, 7};
        tbl[5].rank = '{5, 0, 6, 90};     tbl[5].cols = '{50, 51, 52, 53, 0, 0, 0, 0};
        tbl[5].stall = 0; tbl[5].lanes1 = 0;
        tbl[5].exp_dsum = 11; tbl[5].exp_err = 1; tbl[5].exp_cycles = 27; tbl[5].exp_beats = 1;

        tbl[6].rp = '{0, 33, 33, 33, 33}; tbl[6].sid = '{0, 1, 2, 3};
        tbl[6].rank = '{1, 2, 3, 4};      tbl[6].cols = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[6].stall = 0; tbl[6].lanes1 = 0;
        tbl[6].exp_dsum = 10; tbl[6].exp_err = 1; tbl[6].exp_cycles = 10; tbl[6].exp_beats = 0;

        tbl[7].rp = '{0, 2, 2, 2, 2};     tbl[7].sid = '{0, 1, 2, 3};
        tbl[7].rank = '{7, 1, 2, 3};      tbl[7].cols = '{60, 61, 0, 0, 0, 0, 0, 0};
        tbl[7].stall = 0; tbl[7].lanes1 = 1;
        tbl[7].exp_dsum = 6; tbl[7].exp_err = 0; tbl[7].exp_cycles = 28; tbl[7].exp_beats = 2;

        start0  = 1'b0;
        start1  = 1'b0;
        reset_n = 1'b0;
        load(tbl[0]);
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid",    if0.out_valid, 1'b0);
        check("rst_mask",     if0.out_lane_valid, 2'b00);
        check("rst_ids",      if0.out_node_id, 64'd0);
        check("rst_contrib",  if0.out_contrib, 16'd0);
        check("rst_last",     if0.out_last, 1'b0);
        check("rst_busy",     busy0, 1'b0);
        check("rst_done",     done0, 1'b0);
        check("rst_dangling", dsum0, 16'd0);
        check("rst_csr_err",  err0, 1'b0);
        check("rst_valid1",   if1.out_valid, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int k = 0; k < NV; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

        // Reset during the last source's DIVIDE of a pass that already flagged an error.
        load(tbl[5]);
        @(negedge clock);
        start0 = 1'b1;
        @(posedge clock);
        #1;
        start0 = 1'b0;
        repeat (11) @(posedge clock);
        #1;
        check("pre_rst_busy",     busy0, 1'b1);
        check("pre_rst_dangling", dsum0, 16'd11);
        check("pre_rst_csr_err",  err0, 1'b1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid",    if0.out_valid, 1'b0);
        check("mid_rst_busy",     busy0, 1'b0);
        check("mid_rst_done",     done0, 1'b0);
        check("mid_rst_dangling", dsum0, 16'd0);
        check("mid_rst_csr_err",  err0, 1'b0);
        check("mid_rst_contrib",  if0.out_contrib, 16'd0);
        check("mid_rst_mask",     if0.out_lane_valid, 2'b00);
        check("mid_rst_last",     if0.out_last, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clock);
            #1;
            if (done0) dones++;
        end
        check("post_rst_no_done", dones, 0);
        check("post_rst_idle",    busy0, 1'b0);
        run_vec(tbl[0], "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pagerank_scatter_csr.md
# pagerank_scatter_csr

Multi-lane successor to the serial PageRank scatter stage. It walks one graph partition stored in CSR form, computing `rank/out_degree` once per source node with an internal iterative divider. It then streams that contribution to up to LANES destination nodes per beat over a valid/ready interface into the gather stage. It also accumulates the rank of dangling (zero out-degree) nodes for the redistribution step.

## Interface
- NODES_IN_PARTITION, 4, source nodes in the partition
- EDGES_IN_PARTITION, 32, capacity of col_idx
- NODES_IN_GRAPH, 32, entries in page_rank_old
- RANK_W, 64, rank/contribution width (unsigned fixed point, divider iterations)
- ID_W, 32, node id / CSR pointer width
- LANES, 2, destinations emitted per output beat (≥1)

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin one scatter pass; sampled only in IDLE
- source_id  in  ID_W×NODES_IN_PARTITION  global id of each partition node
- row_ptr  in  ID_W×(NODES_IN_PARTITION+1)  CSR edge offsets
- col_idx  in  ID_W×EDGES_IN_PARTITION  destination ids
- page_rank_old  in  RANK_W×NODES_IN_GRAPH  previous-iteration ranks
- out_ready  in  1  gather stage accepts beat
- out_valid  out  1  beat present
- out_lane_valid  out  LANES  per-lane valid mask, lane 0 filled first
- out_node_id  out  ID_W×LANES  destination ids
- out_contrib  out  RANK_W  contribution shared by all lanes of the beat
- out_last  out  1  final beat for the current source
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass
- dangling_sum  out  RANK_W  saturating sum of ranks of zero out-degree sources this pass
- csr_error  out  1  sticky until next accepted start; malformed CSR seen

## Operation
- States: IDLE, FETCH, DIVIDE, EMIT, NEXT, DONE.
- IDLE: start=1 → FETCH. Clear source index i, csr_error, dangling_sum.
- FETCH:
  - i==NODES_IN_PARTITION → DONE.
  - Otherwise deg = row_ptr[i+1]−row_ptr[i].
  - If row_ptr[i+1]<row_ptr[i] or row_ptr[i+1]>EDGES_IN_PARTITION: set csr_error and treat deg as 0.
  - deg==0: dangling_sum += page_rank_old[source_id[i]] (saturate at 2^RANK_W−1) → NEXT.
  - Otherwise load the divider with a=page_rank_old[source_id[i]], b=deg → DIVIDE.
- DIVIDE: restoring divider, one quotient bit per cycle, exactly RANK_W cycles. Quotient is truncated (floor) and latched as contrib. Edge pointer e=row_ptr[i] → EMIT.
- EMIT:
  - Beat carries k=min(LANES, row_ptr[i+1]−e) edges. Lane n carries col_idx[e+n] with out_lane_valid[n]=1; unused lanes have mask 0 and id 0.
  - out_last=1 when e+k==row_ptr[i+1].
  - On out_valid&out_ready: e+=k. After the last beat → NEXT.
- NEXT: i+=1 → FETCH.
- DONE: done=1 for one cycle → IDLE. dangling_sum and csr_error hold until the next start.
- source_id entries ≥NODES_IN_GRAPH: csr_error set, node treated as deg 0 with rank 0.

## Timing
- Reset values: all outputs 0, state IDLE, i=0, e=0, internal contrib 0. Asserting reset mid-pass aborts immediately, with no done pulse.
- busy=1 in every state except IDLE, starting the cycle after start is accepted. start while busy is ignored.
- Per non-dangling source with out_ready held 1: 1 (FETCH) + RANK_W (DIVIDE) + ceil(deg/LANES) (EMIT) + 1 (NEXT) cycles.
- Per dangling source: 2 cycles.
- Final FETCH + DONE adds 2 cycles.
- Handshake:
  - out_valid asserts only in EMIT and never drops without acceptance.
  - All out_* signals hold stable while out_valid=1 and out_ready=0.
  - out_ready may be high at any time; out_ready without valid has no effect.
  - Back-to-back beats are allowed with no bubble between beats of the same source.
- done and out_valid are never high in the same cycle.

## Test plan
- RANK_W=16, LANES=2, node0 rank 100, row_ptr {0,3,3,3,3}, col_idx {5,6,7}, out_ready=1 → beat1 ids 5,6, mask 11, contrib 33, out_last 0; beat2 id 7, mask 01, out_last 1. dangling_sum = sum of ranks of nodes 1–3. done after 1+16+2+1 + 3×2 + 2 cycles.
- Same stimulus, out_ready toggled 1,0,0,1 → beat held stable through the stall, no beat dropped or duplicated.
- All degrees 0, ranks 0xFFF0 ×4 → no out_valid; dangling_sum saturates to 0xFFFF; done pulses once.
- row_ptr {0,2,1,1,1} → csr_error=1, node1 treated as dangling; node0 emits 2 edges; csr_error clears on the next start.
- Reset asserted during DIVIDE → all outputs 0 and state IDLE the same cycle; a new start runs a full clean pass.
- LANES=1, rank 7, deg 2 → two single-lane beats with contrib 3 (floor); start pulsed while busy is ignored.
